branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter BHT_WIDTH, default 13, global history width; must match the predictor's history width.
REQ-002 Parameter DEPTH, default 4, in-flight branch queue entries; power of two, minimum 2.
REQ-003 Parameter CNT_WIDTH, default 32, statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PredValid  input  1  fetch pushes one predicted conditional branch this cycle.
REQ-007 PredBP  input  1  predicted direction of the pushed branch (1 = taken).
REQ-008 PredHist  input  BHT_WIDTH  history value that indexed the counter table for this prediction.
REQ-009 ResValid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-010 ResZero  input  1  actual outcome of the resolved branch (1 = taken).
REQ-011 Flush  output  1  one-cycle pulse: misprediction, squash younger instructions.
REQ-012 RecoverHist  output  BHT_WIDTH  corrected history for the predictor; valid when Flush = 1.
REQ-013 TrainValid  output  1  one-cycle pulse: update the counter at TrainIdx.
REQ-014 TrainIdx  output  BHT_WIDTH  counter index to train (the stored PredHist).
REQ-015 TrainTaken  output  1  outcome to train with (copy of ResZero).
REQ-016 Full, Empty  output  1 each  queue status, combinational from the registered occupancy.
REQ-017 BranchCount, MissCount  output  CNT_WIDTH each  resolved branches and mispredictions.
REQ-018 Err  output  1  sticky protocol-error flag.

Function
REQ-019 Queue: circular FIFO of DEPTH entries {PredBP, PredHist}; pointers log2(DEPTH) bits plus one wrap bit; occupancy 0..DEPTH.
REQ-020 Push: PredValid=1 and (not Full, or ResValid=1 with Empty=0 in the same cycle) writes an entry at the tail.
REQ-021 Push while Full with no valid pop: entry dropped, Err set, queue unchanged.
REQ-022 Pop: ResValid=1 with Empty=0 removes the head entry; ResValid with Empty=1 is ignored and sets Err.
REQ-023 Mispredict = head.PredBP XOR ResZero, evaluated at pop.
REQ-024 Outputs are registered: TrainValid, TrainIdx, TrainTaken, Flush and RecoverHist become valid exactly one cycle after the pop edge and stay valid for one cycle.
REQ-025 Every pop produces TrainValid=1 with TrainIdx=head.PredHist and TrainTaken=ResZero.
REQ-026 On mispredict, Flush=1 and RecoverHist={head.PredHist[BHT_WIDTH-2:0], ResZero}.
REQ-027 With Flush=0, RecoverHist holds its previous value.
REQ-028 On a mispredicting pop, the whole queue is cleared at that edge: all younger entries are squashed and Empty=1 on the next cycle.
REQ-029 A push in the same cycle as a mispredicting pop is discarded and does not set Err.
REQ-030 BranchCount increments by 1 per pop; MissCount increments by 1 per mispredicting pop; both saturate at 2**CNT_WIDTH-1 with no wrap.
REQ-031 Pop with a simultaneous push at occupancy DEPTH leaves occupancy DEPTH, with correct pointer wrap.

Reset
REQ-032 While reset=1: pointers 0, occupancy 0, Empty=1, Full=0, Flush=0, TrainValid=0, TrainIdx=0, TrainTaken=0, RecoverHist=0, BranchCount=0, MissCount=0, Err=0.
REQ-033 reset has priority over every push, pop and flush in the same cycle; in-flight entries are lost, and no Flush or TrainValid pulse is generated for them afterwards.

Verification
REQ-034 Push {BP=1, Hist=0x0A5}, then ResValid with ResZero=1 -> next cycle TrainValid=1, TrainIdx=0x0A5, TrainTaken=1, Flush=0, BranchCount=1, MissCount=0.
REQ-035 Push {0,0x001},{1,0x002},{1,0x003}; resolve the first with ResZero=1 -> Flush=1, RecoverHist=0x003, MissCount=1, Empty=1; later ResValid -> ignored and Err=1.
REQ-036 Fill to DEPTH=4, then PredValid alone -> Err=1 and occupancy stays 4; then push and correct pop in the same cycle -> occupancy 4, FIFO order preserved across the pointer wrap.
REQ-037 Mispredicting pop with a simultaneous PredValid -> Empty=1 next cycle, Err stays 0.
REQ-038 CNT_WIDTH=2, 5 mispredicting pops -> BranchCount=3, MissCount=3 (saturated).
REQ-039 Assert reset with 3 entries queued and a pop pending -> all outputs at REQ-032 values, and no Flush or TrainValid pulse after reset is released.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : In-flight conditional-branch queue. Fetch pushes each
//               prediction {direction, history}; execute resolves the oldest.
//               Every resolution trains the predictor counter that made the
//               prediction. A misprediction flushes the pipeline, returns the
//               corrected global history and squashes every younger entry.
//               Also keeps saturating branch/miss statistics and a sticky
//               protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int BHT_WIDTH = 13,
  parameter int DEPTH     = 4,   // power of two, at least 2
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PredValid,
  input  logic                 PredBP,
  input  logic [BHT_WIDTH-1:0] PredHist,
  input  logic                 ResValid,
  input  logic                 ResZero,
  output logic                 Flush,
  output logic [BHT_WIDTH-1:0] RecoverHist,
  output logic                 TrainValid,
  output logic [BHT_WIDTH-1:0] TrainIdx,
  output logic                 TrainTaken,
  output logic                 Full,
  output logic                 Empty,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MissCount,
  output logic                 Err
);

  // Slot index width; pointers carry one extra wrap bit above it.
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]          PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]          OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Queue storage: predicted direction and the history that indexed it.
  logic                 bp_mem   [DEPTH];
  logic [BHT_WIDTH-1:0] hist_mem [DEPTH];

  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic [AW:0] occupancy;

  logic                 head_bp;
  logic [BHT_WIDTH-1:0] head_hist;
  logic                 do_pop;
  logic                 mispredict;
  logic                 do_push;
  logic                 push_overflow;
  logic                 pop_underflow;

  assign Empty = (occupancy == '0);
  assign Full  = (occupancy == OCC_FULL);

  assign head_bp   = bp_mem[rd_ptr[AW-1:0]];
  assign head_hist = hist_mem[rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full queue is legal
  // when paired with a valid pop. A mispredicting pop squashes everything,
  // including the branch arriving in that cycle, so that push is discarded
  // silently rather than treated as an overflow.
  assign do_pop        = ResValid & ~Empty;
  assign mispredict    = do_pop & (head_bp ^ ResZero);
  assign do_push       = PredValid & (~Full | do_pop) & ~mispredict;
  assign push_overflow = PredValid & Full & ~do_pop;
  assign pop_underflow = ResValid & Empty;

  // Entry storage carries no reset: slots are only read while occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      bp_mem[wr_ptr[AW-1:0]]   <= PredBP;
      hist_mem[wr_ptr[AW-1:0]] <= PredHist;
    end
  end

  // Pointer and occupancy update; a misprediction empties the queue by
  // snapping the read pointer onto the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (mispredict) begin
      rd_ptr    <= wr_ptr;
      occupancy <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + PTR_ONE;
        2'b01:   occupancy <= occupancy - PTR_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Registered training and recovery outputs, one cycle after the pop edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      TrainValid  <= 1'b0;
      TrainIdx    <= '0;
      TrainTaken  <= 1'b0;
      Flush       <= 1'b0;
      RecoverHist <= '0;
    end else begin
      TrainValid <= do_pop;
      Flush      <= mispredict;
      if (do_pop) begin
        TrainIdx   <= head_hist;
        TrainTaken <= ResZero;
      end
      // Corrected history: the prediction's history shifted by the real outcome.
      if (mispredict) begin
        RecoverHist <= {head_hist[BHT_WIDTH-2:0], ResZero};
      end
    end
  end

  // Saturating resolution statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else begin
      if (do_pop && (BranchCount != CNT_MAX)) begin
        BranchCount <= BranchCount + CNT_ONE;
      end
      if (mispredict && (MissCount != CNT_MAX)) begin
        MissCount <= MissCount + CNT_ONE;
      end
    end
  end

  // Sticky protocol error: overflow push or resolve with nothing in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      Err <= 1'b0;
    end else if (push_overflow || pop_underflow) begin
      Err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed bench for branch_resolve_unit. A queue-based model
//               predicts every output each cycle; literal checks pin the
//               model at the key points of each scenario. A second instance
//               with 2-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int BHT   = 13;
  localparam int DEPTH = 4;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX2  = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           PredValid = 1'b0;
  logic           PredBP = 1'b0;
  logic [BHT-1:0] PredHist = '0;
  logic           ResValid = 1'b0;
  logic           ResZero = 1'b0;

  logic           flush, tv, tk, full, empty, err;
  logic [BHT-1:0] rh, idx;
  logic [31:0]    bc, mc;

  logic           s_flush, s_tv, s_tk, s_full, s_empty, s_err;
  logic [BHT-1:0] s_rh, s_idx;
  logic [1:0]     s_bc, s_mc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.BHT_WIDTH(BHT), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .PredValid(PredValid), .PredBP(PredBP),
    .PredHist(PredHist), .ResValid(ResValid), .ResZero(ResZero),
    .Flush(flush), .RecoverHist(rh), .TrainValid(tv), .TrainIdx(idx),
    .TrainTaken(tk), .Full(full), .Empty(empty), .BranchCount(bc),
    .MissCount(mc), .Err(err)
  );

  branch_resolve_unit #(.BHT_WIDTH(BHT), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .PredValid(PredValid), .PredBP(PredBP),
    .PredHist(PredHist), .ResValid(ResValid), .ResZero(ResZero),
    .Flush(s_flush), .RecoverHist(s_rh), .TrainValid(s_tv), .TrainIdx(s_idx),
    .TrainTaken(s_tk), .Full(s_full), .Empty(s_empty), .BranchCount(s_bc),
    .MissCount(s_mc), .Err(s_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic           bp;
    logic [BHT-1:0] hist;
  } ent_t;

  ent_t           q[$];
  logic           exp_flush = 0, exp_tv = 0, exp_tk = 0, exp_err = 0;
  logic           exp_full = 0, exp_empty = 1;
  logic [BHT-1:0] exp_rh = '0, exp_idx = '0;
  longint         exp_bc = 0, exp_mc = 0, exp_bc2 = 0, exp_mc2 = 0;

  // Model: a list of in-flight branches, resolved oldest-first.
  always @(posedge clk) begin
    ent_t           head;
    logic [BHT-1:0] h;
    bit             pop, miss, room;
    if (reset) begin
      q.delete();
      exp_flush = 0; exp_tv = 0; exp_tk = 0; exp_err = 0;
      exp_rh = '0; exp_idx = '0;
      exp_bc = 0; exp_mc = 0; exp_bc2 = 0; exp_mc2 = 0;
    end else begin
      pop  = ResValid && (q.size() != 0);
      room = (q.size() < DEPTH) || pop;
      miss = 0;
      exp_tv    = pop;
      exp_flush = 0;
      if (ResValid && q.size() == 0) exp_err = 1;
      if (pop) begin
        head    = q[0];
        h       = head.hist;
        exp_idx = h;
        exp_tk  = ResZero;
        miss    = (head.bp != ResZero);
        exp_bc  = (exp_bc  < MAX32) ? exp_bc  + 1 : exp_bc;
        exp_bc2 = (exp_bc2 < MAX2)  ? exp_bc2 + 1 : exp_bc2;
        if (miss) begin
          exp_flush = 1;
          exp_rh    = {h[BHT-2:0], ResZero};
          exp_mc    = (exp_mc  < MAX32) ? exp_mc  + 1 : exp_mc;
          exp_mc2   = (exp_mc2 < MAX2)  ? exp_mc2 + 1 : exp_mc2;
          q.delete();
        end else begin
          void'(q.pop_front());
        end
      end
      if (PredValid && !miss) begin
        if (room) q.push_back({PredBP, PredHist});
        else      exp_err = 1;
      end
    end
    exp_full  = (q.size() == DEPTH);
    exp_empty = (q.size() == 0);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_flush", flush, exp_flush);
    chk("m_recover_hist", rh, exp_rh);
    chk("m_train_valid", tv, exp_tv);
    chk("m_train_idx", idx, exp_idx);
    chk("m_train_taken", tk, exp_tk);
    chk("m_full", full, exp_full);
    chk("m_empty", empty, exp_empty);
    chk("m_branch_count", bc, exp_bc);
    chk("m_miss_count", mc, exp_mc);
    chk("m_err", err, exp_err);
    chk("m_sat_branch_count", s_bc, exp_bc2);
    chk("m_sat_miss_count", s_mc, exp_mc2);
    chk("m_sat_flush", s_flush, exp_flush);
    chk("m_sat_train_valid", s_tv, exp_tv);
    chk("m_sat_empty", s_empty, exp_empty);
    chk("m_sat_full", s_full, exp_full);
    chk("m_sat_err", s_err, exp_err);
    chk("m_sat_idx", s_idx, exp_idx);
    chk("m_sat_taken", s_tk, exp_tk);
    chk("m_sat_rh", s_rh, exp_rh);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic pv, input logic bp, input logic [BHT-1:0] h,
                       input logic rv, input logic rz);
    PredValid = pv; PredBP = bp; PredHist = h; ResValid = rv; ResZero = rz;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_train_valid", tv, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_branch_count", bc, 0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;

    // Correct prediction trains without flushing.
    drive(1, 1, 13'h0A5, 0, 0);
    drive(0, 0, '0, 1, 1);
    chk("ok_train_valid", tv, 1'b1);
    chk("ok_train_idx", idx, 13'h0A5);
    chk("ok_train_taken", tk, 1'b1);
    chk("ok_flush", flush, 1'b0);
    chk("ok_branch_count", bc, 1);
    chk("ok_miss_count", mc, 0);
    idle();
    chk("ok_pulse_ends", tv, 1'b0);

    // Misprediction squashes younger entries; later resolve is an error.
    drive(1, 0, 13'h001, 0, 0);
    drive(1, 1, 13'h002, 0, 0);
    drive(1, 1, 13'h003, 0, 0);
    drive(0, 0, '0, 1, 1);
    chk("mis_flush", flush, 1'b1);
    chk("mis_recover_hist", rh, 13'h003);
    chk("mis_miss_count", mc, 1);
    chk("mis_empty", empty, 1'b1);
    chk("mis_err_clear", err, 1'b0);
    drive(0, 0, '0, 1, 0);
    chk("underflow_err", err, 1'b1);
    chk("underflow_no_train", tv, 1'b0);
    chk("recover_hist_holds", rh, 13'h003);

    // Overflow, then push+pop at full across the pointer wrap.
    do_reset();
    drive(1, 0, 13'h010, 0, 0);
    drive(1, 0, 13'h011, 0, 0);
    drive(1, 1, 13'h012, 0, 0);
    drive(1, 1, 13'h013, 0, 0);
    chk("fill_full", full, 1'b1);
    drive(1, 0, 13'h014, 0, 0);
    chk("overflow_err", err, 1'b1);
    chk("overflow_still_full", full, 1'b1);
    drive(1, 0, 13'h015, 1, 0);
    chk("pushpop_idx", idx, 13'h010);
    chk("pushpop_full", full, 1'b1);
    drive(0, 0, '0, 1, 0);
    chk("order_1", idx, 13'h011);
    drive(0, 0, '0, 1, 1);
    chk("order_2", idx, 13'h012);
    drive(0, 0, '0, 1, 1);
    chk("order_3", idx, 13'h013);
    drive(0, 0, '0, 1, 0);
    chk("order_wrap", idx, 13'h015);
    chk("order_no_flush", flush, 1'b0);
    chk("order_empty", empty, 1'b1);

    // Push during a mispredicting pop is discarded without error.
    do_reset();
    drive(1, 1, 13'h020, 0, 0);
    drive(1, 0, 13'h021, 1, 0);
    chk("squash_push_empty", empty, 1'b1);
    chk("squash_push_err", err, 1'b0);
    chk("squash_push_rh", rh, 13'h040);
    idle();
    chk("squash_push_still_empty", empty, 1'b1);

    // Counter saturation on the 2-bit instance.
    do_reset();
    repeat (5) begin
      drive(1, 1, 13'h030, 0, 0);
      drive(0, 0, '0, 1, 0);
    end
    chk("sat_branch_count", s_bc, 2'd3);
    chk("sat_miss_count", s_mc, 2'd3);
    chk("wide_branch_count", bc, 5);
    chk("wide_miss_count", mc, 5);

    // Reset beats a pending mispredicting pop and push.
    do_reset();
    drive(1, 1, 13'h041, 0, 0);
    drive(1, 1, 13'h042, 0, 0);
    drive(1, 1, 13'h043, 0, 0);
    reset = 1'b1;
    drive(1, 0, 13'h044, 1, 0);
    chk("rstpri_flush", flush, 1'b0);
    chk("rstpri_train_valid", tv, 1'b0);
    chk("rstpri_idx", idx, 13'h000);
    chk("rstpri_taken", tk, 1'b0);
    chk("rstpri_rh", rh, 13'h000);
    chk("rstpri_branch_count", bc, 0);
    chk("rstpri_miss_count", mc, 0);
    chk("rstpri_err", err, 1'b0);
    chk("rstpri_empty", empty, 1'b1);
    chk("rstpri_full", full, 1'b0);
    reset = 1'b0;
    repeat (3) begin
      idle();
      chk("post_rst_no_train", tv, 1'b0);
      chk("post_rst_no_flush", flush, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
